// File: rtl/serial_bit_source_if.sv
// Word-load handshake and serial output bundle for serial_bit_source.
// The master drives load/data_in; the slave (the serializer) drives the rest.
interface serial_bit_source_if #(
    parameter int WIDTH = 9
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             xout;
    logic             bit_valid;
    logic [IDX_W-1:0] bit_idx;
    logic             done;

    modport master (
        output load, data_in,
        input  ready, xout, bit_valid, bit_idx, done
    );

    modport slave (
        input  load, data_in,
        output ready, xout, bit_valid, bit_idx, done
    );
endinterface

// File: rtl/serial_bit_source.sv
// Parallel-to-serial source: shifts a WIDTH-bit word out MSB first on xout,
// holding each bit for DIV clocks, with back-to-back word support.
module serial_bit_source #(
    parameter int   WIDTH      = 9,
    parameter int   DIV        = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic                clock,
    input logic                resetn,
    serial_bit_source_if.slave sif
);
    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [7:0]       DIV_LAST = 8'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [7:0]       div_cnt, div_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             xout_r, xout_n;
    logic             bv_r, bv_n;
    logic             done_r, done_n;

    logic last_cycle;
    logic ready;
    logic accept;

    // The final cycle of a word doubles as an accept slot so words can abut.
    assign last_cycle = (state == SHIFT) && (div_cnt == DIV_LAST) && (idx == IDX_LAST);
    assign ready      = (state == IDLE) || last_cycle;
    assign accept     = sif.load && ready;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        div_n   = div_cnt;
        idx_n   = idx;
        xout_n  = xout_r;
        bv_n    = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                xout_n = IDLE_LEVEL;
                if (accept) begin
                    state_n = SHIFT;
                    shreg_n = sif.data_in;
                    xout_n  = sif.data_in[WIDTH-1];
                    idx_n   = '0;
                    div_n   = '0;
                    bv_n    = 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt != DIV_LAST) begin
                    div_n = div_cnt + 8'd1;
                end else if (idx != IDX_LAST) begin
                    // Rotate rather than shift so the register stays fully used.
                    shreg_n = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
                    xout_n  = shreg[WIDTH-2];
                    idx_n   = idx + IDX_ONE;
                    div_n   = '0;
                    bv_n    = 1'b1;
                end else begin
                    done_n = 1'b1;
                    div_n  = '0;
                    idx_n  = '0;
                    if (accept) begin
                        shreg_n = sif.data_in;
                        xout_n  = sif.data_in[WIDTH-1];
                        bv_n    = 1'b1;
                    end else begin
                        state_n = IDLE;
                        xout_n  = IDLE_LEVEL;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Register stage: every output leaves from a flop, none from load.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            shreg   <= '0;
            div_cnt <= '0;
            idx     <= '0;
            xout_r  <= IDLE_LEVEL;
            bv_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            div_cnt <= div_n;
            idx     <= idx_n;
            xout_r  <= xout_n;
            bv_r    <= bv_n;
            done_r  <= done_n;
        end
    end

    assign sif.ready     = ready;
    assign sif.xout      = xout_r;
    assign sif.bit_valid = bv_r;
    assign sif.bit_idx   = idx;
    assign sif.done      = done_r;
endmodule
